// File: rtl/decode_stage_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, fetch/decode length codes.
// Combinational helpers only; no state.
`ifndef RISCV_DEFINES_SV
`define RISCV_DEFINES_SV
`define RISCV_WORD_WIDTH 32
`define RISCV_ADDR_WIDTH 32
`endif

package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Length codes shared with fetch_stage; fetch pops this many halfwords.
  localparam logic [1:0] LEN_NONE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return IMM_I;
      OPC_STORE:                                  return IMM_S;
      OPC_BRANCH:                                 return IMM_B;
      OPC_LUI, OPC_AUIPC:                         return IMM_U;
      OPC_JAL:                                    return IMM_J;
      default:                                    return IMM_NONE;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

endpackage

// File: rtl/decode_stage_rvc_expander.sv
// RV32C to RV32I expander, purely combinational; F/D loads/stores and reserved encodings flag illegal.
module rvc_expander
  import decode_stage_pkg::*;
(
  input  logic [15:0] c_instr,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6, imm16sp, uimm4spn, uimm_lw, uimm_lwsp, uimm_swsp;
  logic [12:1] boff;
  logic [20:1] joff;
  logic [19:0] lui_imm;

  assign c         = c_instr;
  assign rd        = c[11:7];
  assign rs2       = c[6:2];
  assign rdp       = {2'b01, c[4:2]};
  assign rs1p      = {2'b01, c[9:7]};
  assign imm6      = {{6{c[12]}}, c[12], c[6:2]};
  assign imm16sp   = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0};
  assign uimm4spn  = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign uimm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign uimm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign uimm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
  assign boff      = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
  assign joff      = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
  assign lui_imm   = {{14{c[12]}}, c[12], c[6:2]};

  always_comb begin
    instr   = {16'b0, c};
    illegal = 1'b0;
    case (c[1:0])
      2'b00: case (c[15:13])
        3'b000: begin
          instr   = enc_i(uimm4spn, 5'd2, 3'b000, rdp, OPC_OP_IMM);
          illegal = (uimm4spn == 12'd0);
        end
        3'b010:  instr = enc_i(uimm_lw, rs1p, 3'b010, rdp, OPC_LOAD);
        3'b110:  instr = enc_s(uimm_lw, rdp, rs1p, 3'b010);
        default: illegal = 1'b1;
      endcase
      2'b01: case (c[15:13])
        3'b000: instr = enc_i(imm6, rd, 3'b000, rd, OPC_OP_IMM);
        3'b001: instr = enc_j(joff, 5'd1);
        3'b010: instr = enc_i(imm6, 5'd0, 3'b000, rd, OPC_OP_IMM);
        3'b011: begin
          // rd=x2 selects c.addi16sp; both forms reserve a zero immediate.
          illegal = ({c[12], c[6:2]} == 6'd0);
          if (rd == 5'd2) instr = enc_i(imm16sp, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
          else            instr = {lui_imm, rd, OPC_LUI};
        end
        3'b100: case (c[11:10])
          2'b00: begin
            instr   = enc_i({7'b0, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
            illegal = c[12];
          end
          2'b01: begin
            instr   = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
            illegal = c[12];
          end
          2'b10: instr = enc_i(imm6, rs1p, 3'b111, rs1p, OPC_OP_IMM);
          default: begin
            illegal = c[12];
            case (c[6:5])
              2'b00:   instr = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
              2'b01:   instr = enc_r(7'b0, rdp, rs1p, 3'b100, rs1p);
              2'b10:   instr = enc_r(7'b0, rdp, rs1p, 3'b110, rs1p);
              default: instr = enc_r(7'b0, rdp, rs1p, 3'b111, rs1p);
            endcase
          end
        endcase
        3'b101:  instr = enc_j(joff, 5'd0);
        3'b110:  instr = enc_b(boff, rs1p, 3'b000);
        default: instr = enc_b(boff, rs1p, 3'b001);
      endcase
      2'b10: case (c[15:13])
        3'b000: begin
          instr   = enc_i({7'b0, c[6:2]}, rd, 3'b001, rd, OPC_OP_IMM);
          illegal = c[12];
        end
        3'b010: begin
          instr   = enc_i(uimm_lwsp, 5'd2, 3'b010, rd, OPC_LOAD);
          illegal = (rd == 5'd0);
        end
        3'b100: begin
          if (!c[12]) begin
            if (rs2 == 5'd0) begin
              instr   = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR);
              illegal = (rd == 5'd0);
            end else begin
              instr = enc_r(7'b0, rs2, 5'd0, 3'b000, rd);
            end
          end else if (rs2 == 5'd0) begin
            if (rd == 5'd0) instr = 32'h0010_0073;
            else            instr = enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
          end else begin
            instr = enc_r(7'b0, rs2, rd, 3'b000, rd);
          end
        end
        3'b110:  instr = enc_s(uimm_swsp, rs2, 5'd2, 3'b010);
        default: illegal = 1'b1;
      endcase
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: length detect, RVC expand, field extract into the ID/EX register.
// One cycle from accept to id_valid_o; holds contents while execute stalls, drops them on flush.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit RVC_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [`RISCV_WORD_WIDTH-1:0] instr_i,
  input  logic [`RISCV_ADDR_WIDTH-1:0] instr_addr_i,
  input  logic                         instr_valid_i,
  output logic [1:0]                   retired_len_o,
  output logic                         fetch_req_o,
  input  logic                         halt_i,
  input  logic                         flush_i,
  input  logic                         ex_ready_i,
  output logic                         id_valid_o,
  output logic [31:0]                  id_instr_o,
  output logic [`RISCV_ADDR_WIDTH-1:0] id_pc_o,
  output logic [`RISCV_ADDR_WIDTH-1:0] id_pc_next_o,
  output logic [4:0]                   id_rs1_o,
  output logic [4:0]                   id_rs2_o,
  output logic [4:0]                   id_rd_o,
  output logic [31:0]                  id_imm_o,
  output logic                         id_compressed_o,
  output logic                         id_illegal_o
);

  logic        compressed, accept, dec_illegal, rvc_illegal;
  logic [31:0] dec_instr, rvc_instr, dec_imm;
  logic [`RISCV_ADDR_WIDTH-1:0] pc_next;

  if (RVC_EN) begin : g_rvc
    rvc_expander u_rvc (
      .c_instr (instr_i[15:0]),
      .instr   (rvc_instr),
      .illegal (rvc_illegal)
    );
  end else begin : g_no_rvc
    assign rvc_instr   = {16'b0, instr_i[15:0]};
    assign rvc_illegal = 1'b1;
  end

  assign compressed  = (instr_i[1:0] != 2'b11);
  assign dec_instr   = compressed ? rvc_instr : instr_i[31:0];
  assign dec_illegal = compressed ? rvc_illegal : !opcode_legal(dec_instr[6:0]);
  assign pc_next     = instr_addr_i + (compressed ? `RISCV_ADDR_WIDTH'(2) : `RISCV_ADDR_WIDTH'(4));

  // rst_n gates the handshake so fetch sees no pop while reset is held.
  assign accept        = rst_n & instr_valid_i & ~flush_i & (~id_valid_o | ex_ready_i);
  assign retired_len_o = accept ? (compressed ? LEN_HALF : LEN_WORD) : LEN_NONE;
  assign fetch_req_o   = rst_n & ~halt_i & ~flush_i;

  always_comb begin
    dec_imm = 32'd0;
    case (imm_fmt(dec_instr[6:0]))
      IMM_I:   dec_imm = {{20{dec_instr[31]}}, dec_instr[31:20]};
      IMM_S:   dec_imm = {{20{dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]};
      IMM_B:   dec_imm = {{19{dec_instr[31]}}, dec_instr[31], dec_instr[7],
                          dec_instr[30:25], dec_instr[11:8], 1'b0};
      IMM_U:   dec_imm = {dec_instr[31:12], 12'b0};
      IMM_J:   dec_imm = {{11{dec_instr[31]}}, dec_instr[31], dec_instr[19:12],
                          dec_instr[20], dec_instr[30:21], 1'b0};
      default: dec_imm = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_o      <= 1'b0;
      id_instr_o      <= '0;
      id_pc_o         <= '0;
      id_pc_next_o    <= '0;
      id_rs1_o        <= '0;
      id_rs2_o        <= '0;
      id_rd_o         <= '0;
      id_imm_o        <= '0;
      id_compressed_o <= 1'b0;
      id_illegal_o    <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (accept) begin
      id_valid_o      <= 1'b1;
      id_instr_o      <= dec_instr;
      id_pc_o         <= instr_addr_i;
      id_pc_next_o    <= pc_next;
      id_rs1_o        <= dec_instr[19:15];
      id_rs2_o        <= dec_instr[24:20];
      id_rd_o         <= dec_instr[11:7];
      id_imm_o        <= dec_imm;
      id_compressed_o <= compressed;
      id_illegal_o    <= dec_illegal;
    end else if (ex_ready_i) begin
      id_valid_o <= 1'b0;
    end
  end

endmodule
